// File: rtl/memory_pkg.sv
// Shared constants for the pipeline register slice: default payload width and
// the supported stage-count range.
package memory_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned MaxStages    = 16;

  // Width of an occupancy counter that must represent 0..stages inclusive.
  function automatic int unsigned cnt_width(input int unsigned stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipeline_register_if.sv
// Valid/ready bus for the pipeline register: upstream handshake, downstream
// handshake, flush and occupancy count.
interface pipeline_register_if
  import memory_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned STAGES = 1
);

  localparam int unsigned CntW = cnt_width(STAGES);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [CntW-1:0]  count;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid bit plus a data register with load, synchronous
// flush and asynchronous reset.
module pipe_stage
  import memory_pkg::*;
#(
  parameter int unsigned      WIDTH       = DefaultWidth,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VALUE;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_data  <= RESET_VALUE;
    end else if (i_load) begin
      r_valid <= i_valid;
      // Bubbles leave the data untouched so the last word stays visible.
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipeline_register.sv
// Elastic valid/ready pipeline of STAGES slots with flush and an occupancy
// counter; the ready chain is combinational so a full pipe still streams.
module pipeline_register
  import memory_pkg::*;
#(
  parameter int unsigned      WIDTH       = DefaultWidth,
  parameter int unsigned      STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                 clk,
  input logic                 reset,
  pipeline_register_if.slave  bus
);

  localparam int unsigned CntW = cnt_width(STAGES);

  if (STAGES < 1 || STAGES > MaxStages) begin : g_bad_stages
    $error("pipeline_register: STAGES=%0d outside 1..%0d", STAGES, MaxStages);
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipeline_register: WIDTH must be at least 1");
  end

  logic [STAGES:0]   w_load;
  logic [STAGES-1:0] w_valid;
  logic [WIDTH-1:0]  w_data [STAGES];
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [CntW-1:0]   r_count;

  // A slot may load when empty or when its successor is loading this cycle.
  always_comb begin
    w_load         = '0;
    w_load[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_load[k] = ~w_valid[k] | w_load[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             w_prev_valid;
    logic [WIDTH-1:0] w_prev_data;

    if (k == 0) begin : g_first
      assign w_prev_valid = bus.in_valid;
      assign w_prev_data  = bus.in_data;
    end else begin : g_rest
      assign w_prev_valid = w_valid[k-1];
      assign w_prev_data  = w_data[k-1];
    end

    pipe_stage #(
      .WIDTH      (WIDTH),
      .RESET_VALUE(RESET_VALUE)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load[k]),
      .i_flush(bus.flush),
      .i_valid(w_prev_valid),
      .i_data (w_prev_data),
      .o_valid(w_valid[k]),
      .o_data (w_data[k])
    );
  end

  assign w_in_xfer  = bus.in_valid & bus.in_ready;
  assign w_out_xfer = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (bus.flush) begin
      r_count <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_count <= r_count + CntW'(1);
    end else if (w_out_xfer && !w_in_xfer) begin
      r_count <= r_count - CntW'(1);
    end
  end

  assign bus.in_ready  = w_load[0] & ~bus.flush;
  assign bus.out_valid = w_valid[STAGES-1];
  assign bus.out_data  = w_data[STAGES-1];
  assign bus.count     = r_count;

endmodule

// File: tb/tb_pipeline_register.sv
// Scoreboard bench: three pipeline_register instances (3, 2 and 1 stages) driven
// with directed vectors; per-instance monitors pop expected words on output transfers.
module tb_pipeline_register;

  logic clk;
  logic reset;

  int total;
  int bad;

  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  logic [7:0] q_c[$];

  pipeline_register_if #(.WIDTH(8), .STAGES(3)) bus_a ();
  pipeline_register_if #(.WIDTH(8), .STAGES(2)) bus_b ();
  pipeline_register_if #(.WIDTH(8), .STAGES(1)) bus_c ();

  pipeline_register #(.WIDTH(8), .STAGES(3), .RESET_VALUE(8'hE7)) u_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  pipeline_register #(.WIDTH(8), .STAGES(2), .RESET_VALUE(8'h00)) u_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  pipeline_register #(.WIDTH(8), .STAGES(1), .RESET_VALUE(8'h3C)) u_c (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: an output transfer happens at the next posedge when valid & ready.
  always @(negedge clk) begin
    if (!reset && !bus_a.flush && bus_a.out_valid && bus_a.out_ready) begin
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_word: got %0h expected none at %0t", bus_a.out_data, $time);
      end else begin
        chk("a_out_data", {24'd0, bus_a.out_data}, {24'd0, q_a.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && !bus_b.flush && bus_b.out_valid && bus_b.out_ready) begin
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_word: got %0h expected none at %0t", bus_b.out_data, $time);
      end else begin
        chk("b_out_data", {24'd0, bus_b.out_data}, {24'd0, q_b.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && !bus_c.flush && bus_c.out_valid && bus_c.out_ready) begin
      if (q_c.size() == 0) begin
        total++;
        bad++;
        $display("FAIL c_unexpected_word: got %0h expected none at %0t", bus_c.out_data, $time);
      end else begin
        chk("c_out_data", {24'd0, bus_c.out_data}, {24'd0, q_c.pop_front()});
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0; bus_a.flush = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0; bus_b.flush = 1'b0;
    bus_c.in_valid = 1'b0; bus_c.in_data = '0; bus_c.out_ready = 1'b0; bus_c.flush = 1'b0;

    // Reset state, before any clock edge.
    #3;
    chk("rst_a_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_a_out_data",  32'(bus_a.out_data),  32'hE7);
    chk("rst_a_count",     32'(bus_a.count),     32'd0);
    chk("rst_a_in_ready",  32'(bus_a.in_ready),  32'd1);
    chk("rst_b_out_data",  32'(bus_b.out_data),  32'h00);
    chk("rst_c_out_data",  32'(bus_c.out_data),  32'h3C);
    chk("rst_c_out_valid", 32'(bus_c.out_valid), 32'd0);

    tick();
    tick();
    reset = 1'b0;

    // 3-stage streaming: latency 3, one word per cycle.
    bus_a.out_ready = 1'b1;
    q_a.push_back(8'h11); q_a.push_back(8'h22); q_a.push_back(8'h33);
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'h11;
    chk("s3_in_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    bus_a.in_data = 8'h22;
    tick();
    bus_a.in_data = 8'h33;
    chk("s3_no_early_valid", 32'(bus_a.out_valid), 32'd0);
    tick();
    bus_a.in_valid = 1'b0;
    chk("s3_valid_rises", 32'(bus_a.out_valid), 32'd1);
    chk("s3_count_peak",  32'(bus_a.count),     32'd3);
    tick();
    chk("s3_valid_2", 32'(bus_a.out_valid), 32'd1);
    chk("s3_count_2", 32'(bus_a.count),     32'd2);
    tick();
    chk("s3_valid_3", 32'(bus_a.out_valid), 32'd1);
    tick();
    chk("s3_drained_valid", 32'(bus_a.out_valid), 32'd0);
    chk("s3_drained_count", 32'(bus_a.count),     32'd0);
    chk("s3_data_holds",    32'(bus_a.out_data),  32'h33);

    // Full pipe with simultaneous in/out transfer.
    bus_a.out_ready = 1'b0;
    q_a.push_back(8'h41); q_a.push_back(8'h42); q_a.push_back(8'h43);
    q_a.push_back(8'h44); q_a.push_back(8'h45);
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'h41;
    tick();
    bus_a.in_data = 8'h42;
    tick();
    bus_a.in_data = 8'h43;
    tick();
    bus_a.in_data = 8'h44;
    chk("full_count",    32'(bus_a.count),    32'd3);
    chk("full_in_ready", 32'(bus_a.in_ready), 32'd0);
    bus_a.out_ready = 1'b1;
    #1;
    chk("full_ready_chain", 32'(bus_a.in_ready), 32'd1);
    tick();
    bus_a.in_data = 8'h45;
    chk("full_count_thru_1", 32'(bus_a.count), 32'd3);
    tick();
    bus_a.in_valid = 1'b0;
    chk("full_count_thru_2", 32'(bus_a.count), 32'd3);
    tick();
    tick();
    tick();
    chk("full_drain_count", 32'(bus_a.count),     32'd0);
    chk("full_drain_valid", 32'(bus_a.out_valid), 32'd0);

    // Flush with a word offered on the same cycle.
    bus_a.out_ready = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'h51;
    tick();
    bus_a.in_data = 8'h52;
    tick();
    bus_a.in_data = 8'h53;
    tick();
    chk("flush_pre_count", 32'(bus_a.count), 32'd3);
    bus_a.in_data = 8'h54;
    bus_a.flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(bus_a.in_ready), 32'd0);
    tick();
    bus_a.flush = 1'b0;
    bus_a.in_valid = 1'b0;
    chk("flush_count",     32'(bus_a.count),     32'd0);
    chk("flush_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("flush_out_data",  32'(bus_a.out_data),  32'hE7);
    bus_a.out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("flush_no_ghost", 32'(bus_a.out_valid), 32'd0);

    // Asynchronous reset with two words held.
    bus_a.out_ready = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'h61;
    tick();
    bus_a.in_data = 8'h62;
    tick();
    bus_a.in_valid = 1'b0;
    chk("arst_pre_count", 32'(bus_a.count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("arst_count",     32'(bus_a.count),     32'd0);
    chk("arst_out_data",  32'(bus_a.out_data),  32'hE7);
    @(posedge clk);
    #3;
    reset = 1'b0;
    q_a.push_back(8'h5C);
    bus_a.out_ready = 1'b1;
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'h5C;
    tick();
    bus_a.in_valid = 1'b0;
    chk("arst_accept_count", 32'(bus_a.count),     32'd1);
    chk("arst_lat_1",        32'(bus_a.out_valid), 32'd0);
    tick();
    chk("arst_lat_2", 32'(bus_a.out_valid), 32'd0);
    tick();
    chk("arst_lat_3",  32'(bus_a.out_valid), 32'd1);
    chk("arst_data_3", 32'(bus_a.out_data),  32'h5C);
    tick();
    chk("arst_done_count", 32'(bus_a.count), 32'd0);

    // 2-stage backpressure.
    q_b.push_back(8'hA1); q_b.push_back(8'hA2); q_b.push_back(8'hA3);
    bus_b.in_valid = 1'b1; bus_b.in_data = 8'hA1;
    tick();
    chk("bp_count_1",    32'(bus_b.count),    32'd1);
    chk("bp_in_ready_1", 32'(bus_b.in_ready), 32'd1);
    bus_b.in_data = 8'hA2;
    tick();
    bus_b.in_data = 8'hA3;
    chk("bp_in_ready_full", 32'(bus_b.in_ready), 32'd0);
    tick();
    tick();
    chk("bp_count_full", 32'(bus_b.count),    32'd2);
    chk("bp_stalled",    32'(bus_b.in_ready), 32'd0);
    chk("bp_head",       32'(bus_b.out_data), 32'hA1);
    bus_b.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus_b.in_ready), 32'd1);
    tick();
    bus_b.in_valid = 1'b0;
    chk("bp_count_swap", 32'(bus_b.count), 32'd2);
    tick();
    tick();
    tick();
    chk("bp_drain_count", 32'(bus_b.count),     32'd0);
    chk("bp_drain_valid", 32'(bus_b.out_valid), 32'd0);

    // Single stage with bubbles.
    bus_c.out_ready = 1'b1;
    q_c.push_back(8'h71); q_c.push_back(8'h72);
    bus_c.in_valid = 1'b1; bus_c.in_data = 8'h71;
    tick();
    bus_c.in_valid = 1'b0; bus_c.in_data = 8'hFF;
    chk("s1_valid_1", 32'(bus_c.out_valid), 32'd1);
    chk("s1_count_1", 32'(bus_c.count),     32'd1);
    tick();
    chk("s1_bubble_valid", 32'(bus_c.out_valid), 32'd0);
    chk("s1_bubble_data",  32'(bus_c.out_data),  32'h71);
    bus_c.in_valid = 1'b1; bus_c.in_data = 8'h72;
    tick();
    bus_c.in_valid = 1'b0; bus_c.in_data = 8'hEE;
    chk("s1_valid_2", 32'(bus_c.out_valid), 32'd1);
    tick();
    chk("s1_bubble_data_2", 32'(bus_c.out_data), 32'h72);
    chk("s1_count_end",     32'(bus_c.count),    32'd0);

    tick();
    chk("a_all_delivered", 32'(q_a.size()), 32'd0);
    chk("b_all_delivered", 32'(q_b.size()), 32'd0);
    chk("c_all_delivered", 32'(q_c.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
